// File: rtl/interface_hcsr04_bcd_if.sv
// Bundle of the HC-SR04 front-end signals shared between the ranger front end
// and whatever drives/consumes it (sonar control unit, sensor pins, bench).
//   medir     : measurement request (level), driven by the control unit
//   echo      : HC-SR04 echo pin, asynchronous to the clock
//   trigger   : HC-SR04 trigger pin
//   medida    : distance in BCD, [11:8] centena, [7:4] dezena, [3:0] unidade
//   pronto    : one-cycle pulse, medida/erro valid
//   erro      : measurement timed out
//   db_estado : front-end state code for debug
// slave modport is the front end; master modport is its environment.
interface interface_hcsr04_bcd_if;
    logic        medir;
    logic        echo;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    modport slave (
        input  medir,
        input  echo,
        output trigger,
        output medida,
        output pronto,
        output erro,
        output db_estado
    );

    modport master (
        output medir,
        output echo,
        input  trigger,
        input  medida,
        input  pronto,
        input  erro,
        input  db_estado
    );
endinterface

// File: rtl/interface_hcsr04_bcd.sv
// HC-SR04 ultrasonic ranger front end. On a medir request it fires the trigger
// pulse, times the echo pulse and reports the distance as three BCD digits
// (centimetres, rounded to nearest, saturating at 999) with a one-cycle pronto.
// A missing echo or an over-long echo ends the measurement with erro=1 and
// medida=999 so the consumer never waits forever.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high
//   bus   : interface_hcsr04_bcd_if.slave (medir, echo in; trigger, medida,
//           pronto, erro, db_estado out)
module interface_hcsr04_bcd #(
    parameter int unsigned TRIGGER_CYCLES = 500,
    parameter int unsigned CM_CYCLES      = 2941,
    parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
    input logic                   clock,
    input logic                   reset,
    interface_hcsr04_bcd_if.slave bus
);

    // Wide enough for every count the block ever holds.
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + CM_CYCLES + TRIGGER_CYCLES + 1);

    typedef enum logic [3:0] {
        StInicial     = 4'd0,
        StPreparacao  = 4'd1,
        StEnviaTrig   = 4'd2,
        StEsperaEcho  = 4'd3,
        StMede        = 4'd4,
        StArredonda   = 4'd5,
        StFinalMedida = 4'd6
    } state_t;

    state_t      state;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic [CntW-1:0] cnt;    // trigger width / echo wait / remainder within one cm
    logic [CntW-1:0] width;  // total echo-high cycles, for the long-echo timeout
    logic [11:0] bcd;        // whole centimetres counted so far
    logic        echo_meta;
    logic        echo_sync;

    // Decimal increment with carry unidade->dezena->centena; sticks at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Echo comes straight from the sensor pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
        end else begin
            echo_meta <= bus.echo;
            echo_sync <= echo_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= StInicial;
            trigger <= 1'b0;
            medida  <= 12'h000;
            pronto  <= 1'b0;
            erro    <= 1'b0;
            cnt     <= '0;
            width   <= '0;
            bcd     <= 12'h000;
        end else begin
            case (state)
                StInicial: begin
                    if (bus.medir) begin
                        state <= StPreparacao;
                    end
                end

                StPreparacao: begin
                    cnt     <= '0;
                    width   <= '0;
                    bcd     <= 12'h000;
                    erro    <= 1'b0;
                    trigger <= 1'b1;
                    state   <= StEnviaTrig;
                end

                StEnviaTrig: begin
                    if (cnt == CntW'(TRIGGER_CYCLES - 1)) begin
                        trigger <= 1'b0;
                        cnt     <= '0;
                        state   <= StEsperaEcho;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end

                StEsperaEcho: begin
                    if (echo_sync) begin
                        cnt   <= '0;
                        width <= '0;
                        state <= StMede;
                    end else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                        erro   <= 1'b1;
                        medida <= 12'h999;
                        pronto <= 1'b1;
                        state  <= StFinalMedida;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end

                StMede: begin
                    // The cycle that sees echo low is counted too, so the total
                    // equals the pin-high width (the rise cycle was spent in
                    // espera_echo).
                    width <= width + CntW'(1);
                    if (cnt == CntW'(CM_CYCLES - 1)) begin
                        cnt <= '0;
                        bcd <= bcd_inc(bcd);
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                    if (!echo_sync) begin
                        state <= StArredonda;
                    end else if (width == CntW'(TIMEOUT_CYCLES - 1)) begin
                        erro   <= 1'b1;
                        medida <= 12'h999;
                        pronto <= 1'b1;
                        state  <= StFinalMedida;
                    end
                end

                StArredonda: begin
                    if (cnt >= CntW'(CM_CYCLES / 2)) begin
                        medida <= bcd_inc(bcd);
                    end else begin
                        medida <= bcd;
                    end
                    pronto <= 1'b1;
                    state  <= StFinalMedida;
                end

                StFinalMedida: begin
                    pronto <= 1'b0;
                    state  <= StInicial;
                end

                default: begin
                    trigger <= 1'b0;
                    pronto  <= 1'b0;
                    state   <= StInicial;
                end
            endcase
        end
    end

    assign bus.trigger   = trigger;
    assign bus.medida    = medida;
    assign bus.pronto    = pronto;
    assign bus.erro      = erro;
    assign bus.db_estado = state;

endmodule

// File: tb/tb_interface_hcsr04_bcd.sv
// Directed bench for interface_hcsr04_bcd with scaled-down timing:
// 10-cycle trigger, 21 cycles per cm (round-up threshold 10), 25000-cycle timeout.
module tb_interface_hcsr04_bcd;

    localparam int TRIG = 10;
    localparam int CM   = 21;
    localparam int TMO  = 25000;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [11:0] last_med;

    interface_hcsr04_bcd_if bus ();

    interface_hcsr04_bcd #(
        .TRIGGER_CYCLES(TRIG),
        .CM_CYCLES     (CM),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One measurement started by a single-cycle medir pulse. width=0 means no
    // echo; early raises echo 5 cycles before the trigger ends (the two extra
    // synchronised cycles it then spends high in espera_echo are counted).
    task automatic do_measure(input int width, input bit early, input logic [11:0] exp_med,
                              input logic exp_err, input string tag, output int wait_n);
        int n;
        bus.medir = 1'b1;
        tick;
        bus.medir = 1'b0;
        n = 0;
        while (bus.trigger !== 1'b1 && n < 8) begin
            tick;
            n++;
        end
        check({tag, " trig_delay"}, n, 1);
        n = 0;
        while (bus.trigger === 1'b1 && n < 4 * TRIG) begin
            n++;
            if (early && n == TRIG - 5) bus.echo = 1'b1;
            tick;
        end
        check({tag, " trig_width"}, n, TRIG);
        check({tag, " medida_hold"}, bus.medida, last_med);
        if (width > 0) begin
            bus.echo = 1'b1;
            repeat (width) tick;
            bus.echo = 1'b0;
        end
        n = 0;
        while (bus.pronto !== 1'b1 && n < TMO + 50) begin
            tick;
            n++;
        end
        wait_n = n;
        check({tag, " pronto"}, bus.pronto, 1'b1);
        check({tag, " medida"}, bus.medida, exp_med);
        check({tag, " erro"}, bus.erro, exp_err);
        if (width > 0) check({tag, " latency"}, n, 4);
        last_med = exp_med;
        tick;
        check({tag, " pronto_pulse"}, bus.pronto, 1'b0);
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        last_med  = 12'h000;
        reset     = 1'b1;
        bus.medir = 1'b0;
        bus.echo  = 1'b0;
        #23;
        check("rst trigger", bus.trigger, 1'b0);
        check("rst medida", bus.medida, 12'h000);
        check("rst pronto", bus.pronto, 1'b0);
        check("rst erro", bus.erro, 1'b0);
        check("rst estado", bus.db_estado, 4'd0);
        tick;
        reset = 1'b0;
        repeat (3) tick;

        // Nominal and rounding.
        do_measure(10 * CM, 1'b0, 12'h010, 1'b0, "nominal10", n);
        do_measure(5 * CM + 9, 1'b0, 12'h005, 1'b0, "round_down", n);
        do_measure(5 * CM + 10, 1'b0, 12'h006, 1'b0, "round_up", n);
        do_measure(9, 1'b0, 12'h000, 1'b0, "short", n);
        // Carry chain: 099 -> 100, via counting and via rounding.
        do_measure(100 * CM, 1'b0, 12'h100, 1'b0, "carry100", n);
        do_measure(99 * CM + 10, 1'b0, 12'h100, 1'b0, "carry_round", n);
        do_measure(1000 * CM, 1'b0, 12'h999, 1'b0, "saturate", n);
        do_measure(1000 * CM + 15, 1'b0, 12'h999, 1'b0, "sat_round", n);
        // Echo already high when espera_echo is entered.
        do_measure(10 * CM - 2, 1'b1, 12'h010, 1'b0, "early_echo", n);

        // No echo: timeout after exactly TMO cycles in espera_echo.
        do_measure(0, 1'b0, 12'h999, 1'b1, "timeout", n);
        check("timeout cycles", n, TMO);
        do_measure(20 * CM, 1'b0, 12'h020, 1'b0, "after_tmo", n);

        // Reset in the middle of mede.
        bus.medir = 1'b1;
        tick;
        bus.medir = 1'b0;
        repeat (TRIG + 2) tick;
        bus.echo = 1'b1;
        repeat (100) tick;
        check("mid estado", bus.db_estado, 4'd4);
        #2;
        reset = 1'b1;
        #1;
        check("arst trigger", bus.trigger, 1'b0);
        check("arst medida", bus.medida, 12'h000);
        check("arst estado", bus.db_estado, 4'd0);
        n = 0;
        repeat (4) begin
            tick;
            if (bus.pronto !== 1'b0) n++;
        end
        check("arst no_pronto", n, 0);
        bus.echo = 1'b0;
        reset    = 1'b0;
        last_med = 12'h000;
        repeat (3) tick;
        do_measure(15 * CM, 1'b0, 12'h015, 1'b0, "post_rst15", n);

        // Back-to-back with medir held high.
        bus.medir = 1'b1;
        n = 0;
        while (bus.trigger !== 1'b1 && n < 8) begin
            tick;
            n++;
        end
        repeat (TRIG) tick;
        check("b2b trig1_low", bus.trigger, 1'b0);
        bus.echo = 1'b1;
        repeat (7 * CM) tick;
        bus.echo = 1'b0;
        n = 0;
        while (bus.pronto !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        check("b2b pronto1", bus.pronto, 1'b1);
        check("b2b medida1", bus.medida, 12'h007);
        n = 0;
        while (bus.trigger !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check("b2b trig_gap", n, 3);
        bus.medir = 1'b0;
        check("b2b hold_a", bus.medida, 12'h007);
        repeat (TRIG) tick;
        bus.echo = 1'b1;
        repeat (123 * CM) tick;
        bus.echo = 1'b0;
        check("b2b hold_b", bus.medida, 12'h007);
        n = 0;
        while (bus.pronto !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        check("b2b pronto2", bus.pronto, 1'b1);
        check("b2b medida2", bus.medida, 12'h123);
        check("b2b erro2", bus.erro, 1'b0);
        tick;
        check("b2b pronto2_pulse", bus.pronto, 1'b0);
        repeat (5) tick;
        check("b2b idle", bus.db_estado, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interface_hcsr04_bcd.md
Name: interface_hcsr04_bcd

Overview:
Ultrasonic-ranger front end that sits directly upstream of the sonar control unit. On a `medir` request it:
- drives the HC-SR04 trigger pulse;
- times the echo pulse and converts its width to centimetres as three BCD digits;
- raises `pronto` so the control unit can serialise the distance digits (centena/dezena/unidade) over the UART.

Timeouts are handled and reported, so the control unit never hangs in its wait-for-measurement state.

Parameters:
- TRIGGER_CYCLES, 500, trigger high width in clocks (10 us @ 50 MHz).
- CM_CYCLES, 2941, clocks of echo per centimetre (58.82 us @ 50 MHz).
- TIMEOUT_CYCLES, 1500000, maximum clocks waiting for echo rise, and maximum echo-high duration (30 ms).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- medir  in  1  level; starts a measurement when sampled high in idle.
- echo  in  1  HC-SR04 echo, asynchronous to clock.
- trigger  out  1  HC-SR04 trigger.
- medida  out  12  distance, BCD: [11:8] centena, [7:4] dezena, [3:0] unidade.
- pronto  out  1  one-cycle pulse when medida is valid.
- erro  out  1  high with pronto when the measurement timed out; holds until next start.
- db_estado  out  4  current state code, for debug.

Behaviour:
- Reset value of every output:
  - clock/reset: reset is asynchronous, active-high; the clock is `clock`.
  - reset forces state inicial, trigger=0, medida=12'h000, pronto=0, erro=0, and clears all counters.
- Echo synchronisation: echo passes through a 2-FF synchroniser. All echo decisions use the synchronised signal, adding 2 cycles of fixed latency, which does not affect width measurement.
- State encoding: inicial=0, preparacao=1, envia_trigger=2, espera_echo=3, mede=4, arredonda=5, final_medida=6.
- State transitions and actions:
  - inicial: idle. medir=1 -> preparacao.
  - preparacao: one cycle. Clear cycle counter, BCD counter and erro. -> envia_trigger.
  - envia_trigger: trigger=1 for exactly TRIGGER_CYCLES clocks. -> espera_echo; the cycle counter is cleared on exit.
  - espera_echo: waits for synced echo=1.
    - echo=1 -> mede, with cycle counter cleared.
    - Counter reaching TIMEOUT_CYCLES-1 first -> final_medida with erro=1 and medida=12'h999.
  - mede: counting phase.
    - Each clock increments the cycle counter. At CM_CYCLES-1 the counter wraps to 0 and the BCD counter increments.
    - BCD increment is decimal, with carry unidade->dezena->centena.
    - The BCD counter saturates at 999; no wrap to 000.
    - A separate total-width counter is compared against TIMEOUT_CYCLES. Exceeding it -> final_medida with erro=1 and medida=12'h999.
    - Synced echo falling -> arredonda.
  - arredonda: one cycle.
    - If remainder (cycle counter) >= CM_CYCLES/2 (integer division, 1470 by default), BCD += 1, still saturating at 999.
    - medida <= BCD counter. -> final_medida.
  - final_medida: pronto=1 for this single cycle. -> inicial.
- Output holding and request handling:
  - medida holds its value until the next final_medida; it does not change during a measurement.
  - medir is ignored outside inicial.
  - medir held high produces back-to-back measurements, with a minimum of 2 idle cycles (final_medida, inicial) between trigger pulses.
- Boundary conditions:
  - echo already high on entry to espera_echo: accepted as a rise immediately.
  - echo width < CM_CYCLES/2: result 000, erro=0.
  - Reset mid-operation: immediate return to inicial. trigger drops asynchronously, medida clears to 000, and no pronto is emitted.
- Latency: from the echo falling edge at the pin to pronto is 2 (sync) + 1 (arredonda) + 1 cycles.

Test Plan:
1. Nominal 10 cm: pulse medir for 1 cycle -> trigger high for exactly 500 cycles. Then echo high for 29410 cycles -> one-cycle pronto, medida=12'h010, erro=0.
2. Rounding:
   - echo = 5*2941+1469 cycles -> medida=12'h005.
   - echo = 5*2941+1470 cycles -> medida=12'h006.
3. Saturation: echo = 1000*2941 cycles, with TIMEOUT_CYCLES overridden to 4000000 -> medida=12'h999, erro=0. BCD carry chain checked at 099->100 and 999 (no wrap).
4. Timeout:
   - No echo after trigger -> pronto after 1500000 cycles in espera_echo, erro=1, medida=12'h999.
   - Then a normal 20 cm echo -> erro=0, medida=12'h020.
5. Reset mid-operation: assert reset during mede (echo high) -> trigger=0, medida=000, db_estado=0, no pronto pulse. After reset release, a 15 cm measurement completes with medida=12'h015.
6. Back-to-back: medir held high, echoes of 7 cm and then 123 cm -> two pronto pulses with medida 12'h007 then 12'h123. medida is stable between pulses, and trigger pulses are separated by ≥ 2 idle cycles.
